// File: rtl/cmd_pkg.sv
// cmd_pkg -- shared definitions for the command dispatch path: FSM state
// encoding, 80-bit command word layout and opcodes understood by the pin
// controllers.
package cmd_pkg;

  localparam int CMD_WIDTH = 80;

  // Command word layout (first EBI word lands in [79:64]).
  localparam int START_LSB  = 48;
  localparam int START_W    = 32;
  localparam int UNIT_LSB   = 40;
  localparam int UNIT_W     = 8;
  localparam int OPCODE_LSB = 32;
  localparam int OPCODE_W   = 8;
  localparam int DATA_LSB   = 0;
  localparam int DATA_W     = 32;

  // Opcodes shared with the pin/unit controllers.
  localparam logic [7:0] OP_NOP       = 8'h00;
  localparam logic [7:0] OP_PIN_SET   = 8'h01;
  localparam logic [7:0] OP_PIN_CLR   = 8'h02;
  localparam logic [7:0] OP_PIN_PULSE = 8'h03;
  localparam logic [7:0] OP_SAMPLE    = 8'h04;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    WAIT  = 2'd2,
    ISSUE = 2'd3
  } state_t;

  // Field order matches the bit positions above, so a plain cast of the
  // FIFO word yields the decoded command.
  typedef struct packed {
    logic [31:0] start_time;
    logic [7:0]  unit;
    logic [7:0]  opcode;
    logic [31:0] data;
  } cmd_t;

  function automatic logic unit_valid(input logic [7:0] unit, input int num_units);
    return int'(unit) < num_units;
  endfunction

endpackage

// File: rtl/cmd_time_cmp.sv
// cmd_time_cmp -- wrap-safe modular time compare. "due" is high when now is
// at or past start_time, valid for distances below 2^31 ticks.
module cmd_time_cmp (
  input  logic [31:0] now,
  input  logic [31:0] start_time,
  output logic        due
);

  logic [31:0] diff;

  // NOTE: continuous assigns for pure combinational logic cannot infer a latch.
  assign diff = now - start_time;
  assign due  = ~diff[31];

endmodule

// File: rtl/cmd_dispatcher.sv
// cmd_dispatcher -- pops 80-bit commands from the EBI command FIFO, holds each
// until global_clock reaches its start time, then issues it to a unit
// controller over a strobe/ack handshake.
// Optional ack timeout: define CMD_DISPATCH_TIMEOUT_EN.
module cmd_dispatcher
  import cmd_pkg::*;
#(
  parameter int NUM_UNITS   = 64,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [79:0] cmd_fifo_data_out,
  input  logic        cmd_fifo_empty,
  output logic        cmd_fifo_rd_en,
  input  logic [31:0] global_clock,
  output logic [7:0]  unit_addr,
  output logic [7:0]  unit_opcode,
  output logic [31:0] unit_data,
  output logic        unit_strobe,
  input  logic        unit_ack,
  output logic        busy,
  output logic        err_bad_unit,
  output logic        err_timeout,
  input  logic        err_clr
);

  state_t state;
  cmd_t   cmd_q;
  cmd_t   cmd_in;
  logic   armed;
  logic   time_due;
  logic   due;

`ifdef CMD_DISPATCH_TIMEOUT_EN
  localparam int TO_W = ($clog2(ACK_TIMEOUT + 1) > 8) ? $clog2(ACK_TIMEOUT + 1) : 8;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);
  logic [TO_W-1:0] ack_cnt;
  logic            err_timeout_q;
  assign err_timeout = err_timeout_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign cmd_in = cmd_t'(cmd_fifo_data_out);

  cmd_time_cmp u_time_cmp (
    .now        (global_clock),
    .start_time (cmd_q.start_time),
    .due        (time_due)
  );

  // A zero start time is the host's "run now" marker, regardless of distance.
  assign due  = (cmd_q.start_time == '0) || time_due;
  assign busy = (state != IDLE);

  // The FIFO is non-FWFT: popping during IDLE puts the word on the bus while
  // we sit in LATCH. armed keeps the pop low while reset is asserted.
  assign cmd_fifo_rd_en = armed && (state == IDLE) && !cmd_fifo_empty;

  // Dispatch FSM with registered unit-side outputs and sticky error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cmd_q        <= '0;
      armed        <= 1'b0;
      unit_addr    <= '0;
      unit_opcode  <= '0;
      unit_data    <= '0;
      unit_strobe  <= 1'b0;
      err_bad_unit <= 1'b0;
`ifdef CMD_DISPATCH_TIMEOUT_EN
      ack_cnt       <= '0;
      err_timeout_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      armed <= 1'b1;

      // Clear first so a new error raised below in the same cycle wins.
      if (err_clr) begin
        err_bad_unit <= 1'b0;
`ifdef CMD_DISPATCH_TIMEOUT_EN
        err_timeout_q <= 1'b0;
`endif
      end

      case (state)
        IDLE: begin
          if (cmd_fifo_rd_en) state <= LATCH;
        end

        LATCH: begin
          cmd_q <= cmd_in;
          if (!unit_valid(cmd_in.unit, NUM_UNITS)) begin
            err_bad_unit <= 1'b1;
            state        <= IDLE;
          end else begin
            state <= WAIT;
          end
        end

        WAIT: begin
          if (due) begin
            unit_addr   <= cmd_q.unit;
            unit_opcode <= cmd_q.opcode;
            unit_data   <= cmd_q.data;
            unit_strobe <= 1'b1;
            state       <= ISSUE;
`ifdef CMD_DISPATCH_TIMEOUT_EN
            ack_cnt <= '0;
`endif
          end
        end

        ISSUE: begin
          if (unit_ack) begin
            unit_strobe <= 1'b0;
            state       <= IDLE;
          end
`ifdef CMD_DISPATCH_TIMEOUT_EN
          else if (ack_cnt == TO_LAST) begin
            unit_strobe   <= 1'b0;
            err_timeout_q <= 1'b1;
            state         <= IDLE;
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_dispatcher.sv
// tb_cmd_dispatcher -- scoreboard bench: each pushed command with a valid unit
// is queued as expected; every strobe pops and compares one entry.
// Timeout section active when CMD_DISPATCH_TIMEOUT_EN is defined.
module tb_cmd_dispatcher;
  import cmd_pkg::*;

  localparam int NUM_UNITS   = 64;
  localparam int ACK_TIMEOUT = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [79:0] cmd_fifo_data_out;
  logic        cmd_fifo_empty;
  logic        cmd_fifo_rd_en;
  logic [31:0] global_clock;
  logic [7:0]  unit_addr;
  logic [7:0]  unit_opcode;
  logic [31:0] unit_data;
  logic        unit_strobe;
  logic        unit_ack;
  logic        busy;
  logic        err_bad_unit;
  logic        err_timeout;
  logic        err_clr;

  cmd_dispatcher #(
    .NUM_UNITS   (NUM_UNITS),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .cmd_fifo_data_out (cmd_fifo_data_out),
    .cmd_fifo_empty    (cmd_fifo_empty),
    .cmd_fifo_rd_en    (cmd_fifo_rd_en),
    .global_clock      (global_clock),
    .unit_addr         (unit_addr),
    .unit_opcode       (unit_opcode),
    .unit_data         (unit_data),
    .unit_strobe       (unit_strobe),
    .unit_ack          (unit_ack),
    .busy              (busy),
    .err_bad_unit      (err_bad_unit),
    .err_timeout       (err_timeout),
    .err_clr           (err_clr)
  );

  always #5 clk = ~clk;

  // Non-FWFT FIFO model: word appears the cycle after the pop strobe.
  logic [79:0] fifo_mem [0:63];
  int n_push = 0;
  int n_pop = 0;
  int n_underflow = 0;

  assign cmd_fifo_empty = (n_push == n_pop);

  always @(posedge clk) begin
    if (cmd_fifo_rd_en) begin
      if (n_push == n_pop) begin
        n_underflow <= n_underflow + 1;
      end else begin
        cmd_fifo_data_out <= fifo_mem[n_pop % 64];
        n_pop             <= n_pop + 1;
      end
    end
  end

  cmd_t sb[$];
  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] st, input logic [7:0] unit,
                      input logic [7:0] op, input logic [31:0] d);
    cmd_t c;
    c = '{start_time: st, unit: unit, opcode: op, data: d};
    fifo_mem[n_push % 64] = c;
    n_push = n_push + 1;
    if (int'(unit) < NUM_UNITS) sb.push_back(c);
  endtask

  // Wait (bounded) for a strobe, then compare its fields against the scoreboard.
  task automatic wait_strobe(input int budget, output bit got);
    cmd_t e;
    got = 1'b0;
    for (int i = 0; i < budget && !unit_strobe; i++) @(negedge clk);
    check("strobe_seen", 64'(unit_strobe), 64'd1);
    if (!unit_strobe) return;
    got = 1'b1;
    if (sb.size() == 0) begin
      check("sb_depth_at_strobe", 64'(sb.size()), 64'd1);
      return;
    end
    e = sb.pop_front();
    check("unit_addr", 64'(unit_addr), 64'(e.unit));
    check("unit_opcode", 64'(unit_opcode), 64'(e.opcode));
    check("unit_data", 64'(unit_data), 64'(e.data));
  endtask

  task automatic ack_after(input int delay);
    logic [47:0] snap;
    snap = {unit_addr, unit_opcode, unit_data};
    for (int i = 0; i < delay; i++) @(negedge clk);
    check("strobe_held", 64'(unit_strobe), 64'd1);
    check("outputs_stable", 64'({unit_addr, unit_opcode, unit_data}), 64'(snap));
    unit_ack = 1'b1;
    @(negedge clk);
    unit_ack = 1'b0;
    check("strobe_drop_on_ack", 64'(unit_strobe), 64'd0);
  endtask

  task automatic serve(input int delay);
    bit got;
    wait_strobe(200, got);
    if (got) ack_after(delay);
  endtask

  // Let time run one tick per cycle; report the time value the issuing edge saw.
  task automatic sched(input logic [31:0] gc0, input logic [31:0] st, input logic [7:0] unit,
                       input logic [31:0] d);
    global_clock = gc0;
    push(st, unit, OP_PIN_PULSE, d);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (unit_strobe) break;
      global_clock = global_clock + 1;
    end
    check("sched_issue_time", 64'(global_clock), 64'(st));
    serve(2);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit got;
    int base;
    int cnt;

    unit_ack     = 1'b0;
    err_clr      = 1'b0;
    global_clock = '0;

    repeat (3) @(negedge clk);
    check("reset_outputs",
          64'({cmd_fifo_rd_en, unit_strobe, unit_addr, unit_opcode, unit_data,
               busy, err_bad_unit, err_timeout}), 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Immediate command; start_time 0 issues even when time is far away.
    global_clock = 32'h8000_0005;
    push(32'h0, 8'd3, OP_PIN_SET, 32'hDEAD_BEEF);
    #1;
    check("imm_rd_en", 64'(cmd_fifo_rd_en), 64'd1);
    @(negedge clk);
    check("imm_rd_en_pulse", 64'(cmd_fifo_rd_en), 64'd0);
    check("imm_busy", 64'(busy), 64'd1);
    check("imm_strobe_c1", 64'(unit_strobe), 64'd0);
    @(negedge clk);
    check("imm_strobe_c2", 64'(unit_strobe), 64'd0);
    @(negedge clk);
    check("imm_strobe_c3", 64'(unit_strobe), 64'd1);
    wait_strobe(1, got);
    if (got) ack_after(1);
    check("imm_busy_after_ack", 64'(busy), 64'd0);
    check("imm_pops", 64'(n_pop), 64'd1);

    // Start time already in the past.
    global_clock = 32'd1000;
    push(32'd500, 8'd5, OP_PIN_CLR, 32'h1234_5678);
    serve(0);

    // Future start, then across the 32-bit wrap.
    sched(32'd100, 32'd150, 8'd7, 32'h0000_A5A5);
    sched(32'hFFFF_FFF0, 32'h0000_0010, 8'd8, 32'hCAFE_0001);

    // Frozen time with future start: wait indefinitely; stray ack ignored.
    global_clock = 32'd5;
    push(32'd10, 8'd9, OP_SAMPLE, 32'h0BAD_F00D);
    unit_ack = 1'b1;
    repeat (20) @(negedge clk);
    check("frozen_no_strobe", 64'(unit_strobe), 64'd0);
    check("frozen_busy", 64'(busy), 64'd1);
    unit_ack = 1'b0;
    global_clock = 32'd10;
    serve(0);

    // Bad unit dropped; next command (unit 63, last valid) still issued.
    base = n_pop;
    push(32'h0, 8'd200, OP_PIN_SET, 32'h1111_1111);
    push(32'h0, 8'd63, OP_PIN_SET, 32'h6363_6363);
    serve(1);
    check("bad_unit_flag", 64'(err_bad_unit), 64'd1);
    check("bad_unit_pops", 64'(n_pop), 64'(base + 2));

    // err_clr in the same cycle as a new error (unit 64): error wins.
    push(32'h0, 8'd64, OP_PIN_SET, 32'h6464_6464);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("clr_vs_new_err", 64'(err_bad_unit), 64'd1);
    check("bad64_no_strobe", 64'(unit_strobe), 64'd0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_clr", 64'(err_bad_unit), 64'd0);

    // Three queued commands with slow acks: strict order, one pop each.
    base = n_pop;
    push(32'h0, 8'd10, OP_PIN_SET, 32'hAAAA_0010);
    push(32'h0, 8'd20, OP_PIN_CLR, 32'hBBBB_0020);
    push(32'h0, 8'd30, OP_PIN_PULSE, 32'hCCCC_0030);
    for (int k = 0; k < 3; k++) begin
      serve(10);
      check("order_pops", 64'(n_pop), 64'(base + k + 1));
    end
    check("no_pop_when_empty", 64'(n_underflow), 64'd0);

    // Reset while the strobe is up: drops asynchronously, no replay.
    push(32'h0, 8'd4, OP_PIN_SET, 32'h4444_4444);
    wait_strobe(50, got);
    base = n_pop;
    #2 rst = 1'b0;
    #1;
    check("rst_async_outputs", 64'({unit_strobe, busy, cmd_fifo_rd_en}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_no_replay", 64'({unit_strobe, busy, cmd_fifo_rd_en}), 64'd0);
    check("rst_no_pop", 64'(n_pop), 64'(base));

`ifdef CMD_DISPATCH_TIMEOUT_EN
    push(32'h0, 8'd11, OP_PIN_SET, 32'h1100_0011);
    push(32'h0, 8'd12, OP_PIN_SET, 32'h1200_0012);
    wait_strobe(50, got);
    cnt = 1;
    while (unit_strobe && cnt < 100) begin
      @(negedge clk);
      if (unit_strobe) cnt++;
    end
    check("timeout_strobe_cycles", 64'(cnt), 64'(ACK_TIMEOUT));
    check("timeout_flag", 64'(err_timeout), 64'd1);
    serve(0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("timeout_clr", 64'(err_timeout), 64'd0);
`else
    push(32'h0, 8'd11, OP_PIN_SET, 32'h1100_0011);
    serve(40);
    cnt = 0;
    check("no_timeout_flag", 64'(err_timeout), 64'(cnt));
`endif

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
